// File: rtl/fir_pkg.sv
// Shared constants, default datapath types and the latency rule of the
// block-parallel FIR filter family.
package fir_pkg;

  localparam int FIR_L     = 3;
  localparam int FIR_NTAPS = 102;
  localparam int FIR_DW    = 32;
  localparam int FIR_CW    = 32;
  localparam int FIR_OW    = 64;

  typedef logic signed [FIR_DW-1:0] sample_t;
  typedef logic signed [FIR_CW-1:0] coef_t;
  typedef logic signed [FIR_OW-1:0] acc_t;

  // Product register, one register per adder-tree level, output register.
  function automatic int fir_latency(input int ntaps);
    return 2 + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/parallel_fir_filter_if.sv
// Sample stream, result stream and coefficient-load signals of the
// block-parallel FIR filter, bundled for the source side (master) and
// the filter itself (slave).
interface parallel_fir_filter_if #(
  parameter int L     = fir_pkg::FIR_L,
  parameter int DW    = fir_pkg::FIR_DW,
  parameter int CW    = fir_pkg::FIR_CW,
  parameter int OW    = fir_pkg::FIR_OW,
  parameter int NTAPS = fir_pkg::FIR_NTAPS,
  parameter int AW    = $clog2(NTAPS)
);

  logic            in_valid;
  logic [L*DW-1:0] x_in;
  logic            out_valid;
  logic [L*OW-1:0] y_out;
  logic            coef_wr_en;
  logic [AW-1:0]   coef_wr_addr;
  logic [CW-1:0]   coef_wr_data;
  logic            coef_commit;
  logic [7:0]      latency;

  modport master (
    output in_valid, x_in, coef_wr_en, coef_wr_addr, coef_wr_data, coef_commit,
    input  out_valid, y_out, latency
  );

  modport slave (
    input  in_valid, x_in, coef_wr_en, coef_wr_addr, coef_wr_data, coef_commit,
    output out_valid, y_out, latency
  );

endinterface

// File: rtl/fir_lane_tree.sv
// One output lane: registered full-precision products followed by a
// binary adder tree with a register on every level. The tree is laid out
// as a heap padded to the next power of two so every leaf sits at the
// same depth; padding leaves are constant zero.
module fir_lane_tree
  import fir_pkg::*;
#(
  parameter int NTAPS = FIR_NTAPS,
  parameter int DW    = FIR_DW,
  parameter int CW    = FIR_CW,
  parameter int OW    = FIR_OW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] i_x [NTAPS],
  input  logic signed [CW-1:0] i_h [NTAPS],
  output logic signed [OW-1:0] o_sum
);

  localparam int LEVELS = fir_latency(NTAPS) - 2;
  localparam int P      = 1 << LEVELS;
  localparam int PW     = DW + CW;

  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [OW-1:0] sum_t;

  prod_t r_prod_p0 [NTAPS];
  sum_t  r_tree    [P-1];
  sum_t  w_node    [2*P-1];

  // Stage 0 -> products: operands widened first so the product is exact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) r_prod_p0[i] <= '0;
    end else begin
      for (int i = 0; i < NTAPS; i++) r_prod_p0[i] <= prod_t'(i_x[i]) * prod_t'(i_h[i]);
    end
  end

  // Heap view: internal nodes are tree registers, leaves are sign-extended products.
  for (genvar n = 0; n < P-1; n++) begin : g_inner
    assign w_node[n] = r_tree[n];
  end

  for (genvar t = 0; t < P; t++) begin : g_leaf
    if (t < NTAPS) begin : g_prod
      assign w_node[P-1+t] = sum_t'(r_prod_p0[t]);
    end else begin : g_pad
      assign w_node[P-1+t] = '0;
    end
  end

  // Products -> root: each level adds its two children, wrapping modulo 2^OW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < P-1; n++) r_tree[n] <= '0;
    end else begin
      for (int n = 0; n < P-1; n++) r_tree[n] <= w_node[2*n+1] + w_node[2*n+2];
    end
  end

  assign o_sum = w_node[0];

endmodule

// File: rtl/parallel_fir_filter.sv
// L-lane block-parallel pipelined FIR. Holds the sample history, the
// shadow/active coefficient banks, the valid pipe and the output register;
// one fir_lane_tree per lane does the multiply-accumulate.
module parallel_fir_filter
  import fir_pkg::*;
#(
  parameter int L     = FIR_L,
  parameter int NTAPS = FIR_NTAPS,
  parameter int DW    = FIR_DW,
  parameter int CW    = FIR_CW,
  parameter int OW    = FIR_OW,
  parameter int AW    = $clog2(NTAPS)
) (
  input logic                  clk,
  input logic                  rst,
  parallel_fir_filter_if.slave bus
);

  localparam int LATENCY = fir_latency(NTAPS);
  localparam int HLEN    = NTAPS - 1;

  typedef logic signed [DW-1:0] smp_t;
  typedef logic signed [CW-1:0] cf_t;
  typedef logic signed [OW-1:0] out_t;

  // r_hist[0] is the newest past sample, r_hist[j] is j+1 samples older.
  smp_t            w_lane_x     [L];
  smp_t            r_hist       [HLEN];
  smp_t            w_hist_nxt   [HLEN];
  cf_t             r_shadow     [NTAPS];
  cf_t             r_active     [NTAPS];
  cf_t             w_shadow_nxt [NTAPS];
  logic            w_wr_ok;
  logic [AW-1:0]   w_wr_addr;
  logic [LATENCY-1:0] r_vld;
  out_t            w_sum        [L];
  out_t            r_y          [L];
  logic [L*OW-1:0] w_y_flat;

  // Unpack the input block into lanes.
  always_comb begin
    for (int l = 0; l < L; l++) w_lane_x[l] = bus.x_in[l*DW +: DW];
  end

  // Next history: the current block (newest lane first) followed by the
  // older history shifted down by one block.
  for (genvar j = 0; j < HLEN; j++) begin : g_hist
    if (j < L) begin : g_new
      assign w_hist_nxt[j] = w_lane_x[L-1-j];
    end else begin : g_old
      assign w_hist_nxt[j] = r_hist[j-L];
    end
  end

  // History advances by one block only on accepted input blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < HLEN; j++) r_hist[j] <= '0;
    end else if (bus.in_valid) begin
      for (int j = 0; j < HLEN; j++) r_hist[j] <= w_hist_nxt[j];
    end
  end

  assign w_wr_addr = bus.coef_wr_addr;
  assign w_wr_ok   = bus.coef_wr_en && (32'(w_wr_addr) < NTAPS);

  // Shadow bank including this cycle's write, so a same-cycle commit sees it.
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (w_wr_ok) w_shadow_nxt[w_wr_addr] = bus.coef_wr_data;
  end

  // Coefficient banks: the active bank changes only on commit, so the block
  // presented on the commit cycle still multiplies with the old set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NTAPS; i++) r_shadow[i] <= w_shadow_nxt[i];
      if (bus.coef_commit) begin
        for (int i = 0; i < NTAPS; i++) r_active[i] <= w_shadow_nxt[i];
      end
    end
  end

  // Lane l sees x[L*k+l-i]: current-block lanes for i<=l, history otherwise.
  for (genvar l = 0; l < L; l++) begin : g_lane
    smp_t w_taps [NTAPS];

    for (genvar i = 0; i < NTAPS; i++) begin : g_tap
      if (i <= l) begin : g_cur
        assign w_taps[i] = w_lane_x[l-i];
      end else begin : g_past
        assign w_taps[i] = r_hist[i-l-1];
      end
    end

    fir_lane_tree #(
      .NTAPS (NTAPS),
      .DW    (DW),
      .CW    (CW),
      .OW    (OW)
    ) u_tree (
      .clk   (clk),
      .rst   (rst),
      .i_x   (w_taps),
      .i_h   (r_active),
      .o_sum (w_sum[l])
    );
  end

  // Valid pipe: one bit per pipeline register, free-running (no backpressure).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_vld <= '0;
    else      r_vld <= {r_vld[LATENCY-2:0], bus.in_valid};
  end

  // Tree root -> output: capture only valid results, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < L; l++) r_y[l] <= '0;
    end else if (r_vld[LATENCY-2]) begin
      for (int l = 0; l < L; l++) r_y[l] <= w_sum[l];
    end
  end

  // Pack the output lanes.
  always_comb begin
    w_y_flat = '0;
    for (int l = 0; l < L; l++) w_y_flat[l*OW +: OW] = r_y[l];
  end

  assign bus.y_out     = w_y_flat;
  assign bus.out_valid = r_vld[LATENCY-1];
  assign bus.latency   = 8'(LATENCY);

endmodule

// File: tb/tb_parallel_fir_filter.sv
// Randomised and directed bench for parallel_fir_filter against a
// sample-level convolution model.
module tb_parallel_fir_filter;
  import fir_pkg::*;

  localparam int L     = 3;
  localparam int NTAPS = 102;
  localparam int DW    = 32;
  localparam int CW    = 32;
  localparam int OW    = 64;
  localparam int AW    = $clog2(NTAPS);
  localparam int LAT   = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  parallel_fir_filter_if #(.L(L), .DW(DW), .CW(CW), .OW(OW), .NTAPS(NTAPS)) bus ();

  parallel_fir_filter #(
    .L(L), .NTAPS(NTAPS), .DW(DW), .CW(CW), .OW(OW), .AW(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: the whole sample stream since reset, the two banks, and the
  // expected output blocks in order.
  longint m_shadow [NTAPS];
  longint m_active [NTAPS];
  longint hset     [NTAPS];
  longint xs   [$];
  longint expq [$];
  longint m_last [L];
  longint blk    [L];
  bit     vhist  [LAT];
  int     ncnt = 0;
  int     t_in = -1;
  int     t_out = -1;
  bit     arm = 1'b0;

  function automatic longint sx32(input longint v);
    logic signed [31:0] t;
    t = v[31:0];
    return longint'(t);
  endfunction

  function automatic longint ref_y(input int n);
    longint acc = 0;
    for (int i = 0; i < NTAPS; i++)
      if (n - i >= 0) acc += m_active[i] * xs[n-i];
    return acc;
  endfunction

  task automatic model_clear();
    xs.delete();
    expq.delete();
    for (int i = 0; i < NTAPS; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    for (int l = 0; l < L; l++) m_last[l] = 0;
    for (int k = 0; k < LAT; k++) vhist[k] = 1'b0;
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cyc(input bit v, input bit we, input int addr,
                     input longint wd, input bit cm);
    longint wv;
    bus.in_valid     = v;
    for (int l = 0; l < L; l++) begin
      wv = blk[l];
      bus.x_in[l*DW +: DW] = wv[DW-1:0];
    end
    bus.coef_wr_en   = we;
    bus.coef_wr_addr = AW'(addr);
    bus.coef_wr_data = wd[CW-1:0];
    bus.coef_commit  = cm;
    if (v) begin
      for (int l = 0; l < L; l++) xs.push_back(sx32(blk[l]));
      for (int l = 0; l < L; l++) expq.push_back(ref_y(xs.size() - L + l));
    end
    if (we && addr < NTAPS) m_shadow[addr] = sx32(wd);
    if (cm) m_active = m_shadow;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic set_blk(input longint v);
    for (int l = 0; l < L; l++) blk[l] = v;
  endtask

  task automatic load_h();
    for (int i = 0; i < NTAPS; i++) cyc(1'b0, 1'b1, i, hset[i], 1'b0);
    cyc(1'b0, 1'b0, 0, 0, 1'b1);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      ncnt++;
      if (arm && bus.in_valid && t_in < 0)  t_in  = ncnt;
      if (arm && bus.out_valid && t_out < 0) t_out = ncnt;
      chk("out_valid", bus.out_valid, vhist[LAT-1]);
      for (int k = LAT-1; k > 0; k--) vhist[k] = vhist[k-1];
      vhist[0] = bus.in_valid;
      if (bus.out_valid) begin
        if (expq.size() < L) begin
          chk("exp_underflow", expq.size(), L);
        end else begin
          for (int l = 0; l < L; l++) begin
            m_last[l] = expq.pop_front();
            chk($sformatf("y_lane%0d", l), bus.y_out[l*OW +: OW], m_last[l]);
          end
        end
      end else begin
        for (int l = 0; l < L; l++)
          chk($sformatf("y_hold%0d", l), bus.y_out[l*OW +: OW], m_last[l]);
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.x_in = '0;
    bus.coef_wr_en = 1'b0;
    bus.coef_wr_addr = '0;
    bus.coef_wr_data = '0;
    bus.coef_commit = 1'b0;
    set_blk(0);
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    for (int l = 0; l < L; l++) chk("rst_y", bus.y_out[l*OW +: OW], 0);
    chk("latency_port", bus.latency, LAT);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Impulse with h[i]=i+1.
    for (int i = 0; i < NTAPS; i++) hset[i] = i + 1;
    load_h();
    arm = 1'b1;
    set_blk(0);
    blk[0] = 1;
    cyc(1'b1, 1'b0, 0, 0, 1'b0);
    set_blk(0);
    repeat (40) cyc(1'b1, 1'b0, 0, 0, 1'b0);
    idle(12);
    arm = 1'b0;
    chk("first_out_latency", t_out - t_in, LAT);

    // Same impulse with in_valid pattern 1,0,0,...
    for (int c = 0; c < 120; c++) begin
      set_blk(0);
      if (c == 0) blk[0] = 1;
      cyc((c % 3) == 0, 1'b0, 0, 0, 1'b0);
    end
    idle(12);

    // Step: h=1, x=5.
    for (int i = 0; i < NTAPS; i++) hset[i] = 1;
    load_h();
    set_blk(5);
    repeat (40) cyc(1'b1, 1'b0, 0, 0, 1'b0);
    idle(12);
    for (int l = 0; l < L; l++) chk("step_final", bus.y_out[l*OW +: OW], 510);

    // Coefficient swap mid-stream: x=1, shadow filled with 2 while streaming.
    set_blk(1);
    repeat (40) cyc(1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < NTAPS; i++) cyc(1'b1, 1'b1, i, 2, i == NTAPS-1);
    repeat (40) cyc(1'b1, 1'b0, 0, 0, 1'b0);
    idle(12);
    for (int l = 0; l < L; l++) chk("swap_final", bus.y_out[l*OW +: OW], 204);

    // Reset while results are streaming out.
    repeat (12) begin
      for (int l = 0; l < L; l++) blk[l] = sx32(longint'($urandom()));
      cyc(1'b1, 1'b0, 0, 0, 1'b0);
    end
    chk("pre_rst_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    bus.coef_wr_en = 1'b0;
    bus.coef_commit = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_async_valid", bus.out_valid, 0);
    for (int l = 0; l < L; l++) chk("rst_async_y", bus.y_out[l*OW +: OW], 0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) begin
      for (int l = 0; l < L; l++) blk[l] = sx32(longint'($urandom()));
      cyc(1'b1, 1'b0, 0, 0, 1'b0);
    end
    idle(12);
    for (int l = 0; l < L; l++) chk("post_rst_zero", bus.y_out[l*OW +: OW], 0);

    // Wrap/corner: h[0]=x=-2^31; an out-of-range write is ignored.
    for (int i = 0; i < NTAPS; i++) hset[i] = 0;
    hset[0] = -64'sd2147483648;
    for (int i = 0; i < NTAPS; i++) cyc(1'b0, 1'b1, i, hset[i], 1'b0);
    cyc(1'b0, 1'b1, 127, 777, 1'b0);
    cyc(1'b0, 1'b0, 0, 0, 1'b1);
    set_blk(-64'sd2147483648);
    repeat (40) cyc(1'b1, 1'b0, 0, 0, 1'b0);
    idle(12);
    for (int l = 0; l < L; l++)
      chk("wrap_max", bus.y_out[l*OW +: OW], 64'sh4000_0000_0000_0000);
    // Write and commit on the same cycle: the new h[0] is committed.
    cyc(1'b1, 1'b1, 0, 3, 1'b1);
    repeat (40) cyc(1'b1, 1'b0, 0, 0, 1'b0);
    idle(12);
    for (int l = 0; l < L; l++)
      chk("same_cycle_commit", bus.y_out[l*OW +: OW], -64'sd6442450944);

    // Random coefficients, samples, gaps, writes and commits.
    for (int i = 0; i < NTAPS; i++) hset[i] = sx32(longint'($urandom()));
    load_h();
    repeat (300) begin
      for (int l = 0; l < L; l++) blk[l] = sx32(longint'($urandom()));
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 127), longint'($urandom()), $urandom_range(0, 24) == 0);
    end
    idle(12);
    chk("queue_drained", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
